pc_stack_unit: RTL and testbench
================================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL provide parameter AW, default 13, meaning PC/address width in bits.
REQ-002 SHALL provide parameter DEPTH, default 4, meaning return-stack entries (power of two, >=2).
REQ-003 SHALL provide parameter RST_VEC, default 0, meaning the PC value loaded at reset (AW bits).
REQ-004 SHALL provide port clk input 1, system clock; all state changes on its rising edge.
REQ-005 SHALL provide port rst input 1, reset, asynchronous, active-low.
REQ-006 SHALL provide port stall input 1, which freezes all state when high.
REQ-007 SHALL provide port inc_pc input 1, which increments the PC by one.
REQ-008 SHALL provide port load input 1, which loads the PC absolutely from ir_addr.
REQ-009 SHALL provide port ir_addr input AW, the absolute target for load and call.
REQ-010 SHALL provide port br_rel input 1, which adds the signed offset to the PC.
REQ-011 SHALL provide port offset input AW, a two's-complement relative displacement.
REQ-012 SHALL provide port call input 1, which pushes PC+1 and jumps to ir_addr.
REQ-013 SHALL provide port ret input 1, which pops the top of stack into the PC.
REQ-014 SHALL provide port pc_addr output AW, the current program counter (registered).
REQ-015 SHALL provide port stk_level output clog2(DEPTH)+1, the number of valid stack entries.
REQ-016 SHALL provide port stk_full output 1, high when stk_level==DEPTH (combinational from level).
REQ-017 SHALL provide port stk_empty output 1, high when stk_level==0.
REQ-018 SHALL provide port stk_err output 1, sticky overflow/underflow flag.

Function
REQ-019 SHALL resolve operation priority per cycle as ret > call > load > br_rel > inc_pc, with exactly one operation executed.
REQ-020 SHALL leave pc_addr, the stack, stk_level and stk_err unchanged in any cycle with stall=1, regardless of other inputs.
REQ-021 SHALL hold pc_addr when no operation input is asserted.
REQ-022 SHALL update pc_addr to (pc_addr+1) mod 2^AW on inc_pc, so 2^AW-1 wraps to 0.
REQ-023 SHALL update pc_addr to (pc_addr+offset) mod 2^AW on br_rel, with offset sign-interpreted and the carry discarded.
REQ-024 SHALL update pc_addr to ir_addr on load.
REQ-025 SHALL, on call with stk_full=0, write (pc_addr+1) mod 2^AW to entry stk_level, increment stk_level and set pc_addr to ir_addr, all in one cycle.
REQ-026 SHALL, on call with stk_full=1, perform no push, leave pc_addr unchanged and set stk_err.
REQ-027 SHALL, on ret with stk_empty=0, set pc_addr to entry stk_level-1 and decrement stk_level in one cycle.
REQ-028 SHALL, on ret with stk_empty=1, leave pc_addr and stk_level unchanged and set stk_err.
REQ-029 SHALL treat simultaneous call and ret as ret only, with call ignored and no error raised for the ignored call.
REQ-030 SHALL make every operation take effect with 1-cycle latency, so pc_addr reflects the operation after the rising edge on which it was sampled.
REQ-031 SHALL clear stk_err only by reset, never by a valid operation.
REQ-032 SHALL NOT reset stack entry contents; contents above stk_level are don't-care.

Reset
REQ-033 SHALL, while rst=0, force pc_addr=RST_VEC, stk_level=0, stk_err=0, stk_empty=1 and stk_full=0, asynchronously and independent of clk.
REQ-034 SHALL let a reset asserted mid-sequence discard all pending stack state, with the first edge after deassertion treated as a normal cycle.

Verification
REQ-035 SHALL cover reset then inc_pc x3 from defaults -> pc_addr 0,1,2,3; with pc_addr=0x1FFF, inc_pc -> 0x0000.
REQ-036 SHALL cover pc_addr=0x0010 with br_rel offset=0x1FFC (-4) -> 0x000C; then offset=0x0005 -> 0x0011.
REQ-037 SHALL cover pc_addr=0x0020 with call ir_addr=0x0100, then ret -> 0x0100 then 0x0021, with stk_level 1 then 0.
REQ-038 SHALL cover DEPTH=4 with five nested calls -> stk_full=1 after the fourth, fifth ignored (pc unchanged) and stk_err=1; then four rets return to the addresses in LIFO order; a further ret holds pc.
REQ-039 SHALL cover load+inc_pc+br_rel asserted together with ir_addr=0x0AAA -> 0x0AAA; any op with stall=1 -> pc_addr unchanged.
REQ-040 SHALL cover rst pulsed low asynchronously between edges with stk_level=2 -> pc_addr=RST_VEC, stk_level=0, stk_err=0 immediately.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with increment/branch/load and a LIFO return-address stack
module pc_stack_unit #(
  parameter int AW = 13,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RST_VEC = '0,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          inc_pc,
  input  logic          load,
  input  logic [AW-1:0] ir_addr,
  input  logic          br_rel,
  input  logic [AW-1:0] offset,
  input  logic          call,
  input  logic          ret,
  output logic [AW-1:0] pc_addr,
  output logic [LW-1:0] stk_level,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          stk_err
);
  logic [AW-1:0] stack [DEPTH];
  logic [AW-1:0] pc_nxt, pc_inc, top;
  logic [LW-1:0] lvl_nxt, lvl_dec;
  logic          err_nxt, push;
  assign stk_full  = stk_level == LW'(DEPTH);
  assign stk_empty = stk_level == '0;
  assign lvl_dec   = stk_level - LW'(1);
  assign pc_inc    = pc_addr + AW'(1);
  assign top       = stack[lvl_dec[LW-2:0]];
  assign push      = !stall && !ret && call && !stk_full;
  always_comb begin
    pc_nxt  = ret ? (stk_empty ? pc_addr : top) :
              call ? (stk_full ? pc_addr : ir_addr) :
              load ? ir_addr :
              br_rel ? pc_addr + offset :
              inc_pc ? pc_inc : pc_addr;
    lvl_nxt = ret ? (stk_empty ? stk_level : lvl_dec) :
              (call && !stk_full) ? stk_level + LW'(1) : stk_level;
    err_nxt = stk_err || (ret ? stk_empty : call && stk_full);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_addr   <= RST_VEC;
      stk_level <= '0;
      stk_err   <= 1'b0;
    end else if (!stall) begin
      pc_addr   <= pc_nxt;
      stk_level <= lvl_nxt;
      stk_err   <= err_nxt;
    end
  always_ff @(posedge clk)
    if (push) stack[stk_level[LW-2:0]] <= pc_inc;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: scoreboard bench for pc_stack_unit against a queue-based reference model
module tb_pc_stack_unit;
  logic        clk = 0, rst = 0, stall = 0, inc_pc = 0, load = 0, br_rel = 0, call = 0, ret = 0;
  logic [12:0] ir_addr = '0, offset = '0, pc_addr;
  logic [2:0]  stk_level;
  logic        stk_full, stk_empty, stk_err;
  typedef struct {
    logic [12:0] pc;
    logic [2:0]  lvl;
    logic        err;
  } exp_t;
  exp_t        exp_q[$];
  logic [12:0] m_stk[$];
  logic [12:0] m_pc = '0;
  logic        m_err = 0;
  int          n_vec = 0, n_err = 0;
  pc_stack_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .inc_pc(inc_pc), .load(load), .ir_addr(ir_addr),
    .br_rel(br_rel), .offset(offset), .call(call), .ret(ret), .pc_addr(pc_addr),
    .stk_level(stk_level), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask
  task automatic chk_all(input string tag, input logic [12:0] pc, input logic [2:0] lvl, input logic err);
    chk({tag, ".pc"}, 32'(pc_addr), 32'(pc));
    chk({tag, ".lvl"}, 32'(stk_level), 32'(lvl));
    chk({tag, ".err"}, 32'(stk_err), 32'(err));
    chk({tag, ".full"}, 32'(stk_full), 32'(lvl == 3'd4));
    chk({tag, ".empty"}, 32'(stk_empty), 32'(lvl == 3'd0));
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk_all("op", e.pc, e.lvl, e.err);
    end
  end
  task automatic op(input logic st, input logic r, input logic c, input logic l, input logic b,
                    input logic i, input logic [12:0] a, input logic [12:0] off);
    exp_t e;
    @(negedge clk);
    {stall, ret, call, load, br_rel, inc_pc, ir_addr, offset} = {st, r, c, l, b, i, a, off};
    if (!st) begin
      if (r) begin
        if (m_stk.size() == 0) m_err = 1;
        else m_pc = m_stk.pop_back();
      end else if (c) begin
        if (m_stk.size() == 4) m_err = 1;
        else begin
          m_stk.push_back(m_pc + 13'd1);
          m_pc = a;
        end
      end else if (l) m_pc = a;
      else if (b) m_pc = m_pc + off;
      else if (i) m_pc = m_pc + 13'd1;
    end
    e.pc = m_pc;
    e.lvl = 3'(m_stk.size());
    e.err = m_err;
    exp_q.push_back(e);
  endtask
  task automatic idle();
    @(negedge clk);
    {stall, ret, call, load, br_rel, inc_pc} = '0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    #12 chk_all("reset", 13'h0, 3'd0, 1'b0);
    @(negedge clk) rst = 1;
    repeat (3) op(0, 0, 0, 0, 0, 1, 0, 0);
    op(0, 0, 0, 1, 0, 0, 13'h1FFF, 0);
    op(0, 0, 0, 0, 0, 1, 0, 0);
    op(0, 0, 0, 1, 0, 0, 13'h0010, 0);
    op(0, 0, 0, 0, 1, 0, 0, 13'h1FFC);
    op(0, 0, 0, 0, 1, 0, 0, 13'h0005);
    op(0, 0, 0, 1, 0, 0, 13'h0020, 0);
    op(0, 0, 1, 0, 0, 0, 13'h0100, 0);
    op(0, 1, 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 0, 0, 13'h0040, 0);
    for (int k = 1; k <= 5; k++) op(0, 0, 1, 0, 0, 0, 13'(k * 'h100), 0);
    repeat (5) op(0, 1, 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 1, 1, 13'h0AAA, 13'h0003);
    op(1, 0, 1, 1, 1, 1, 13'h0555, 13'h0007);
    op(1, 1, 0, 0, 0, 0, 0, 0);
    op(0, 1, 1, 0, 0, 0, 13'h0300, 0);
    for (int k = 0; k < 300; k++)
      op($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
         $urandom_range(1), $urandom_range(1), 13'($urandom), 13'($urandom));
    idle();
    op(0, 0, 0, 1, 0, 0, 13'h0033, 0);
    op(0, 0, 1, 0, 0, 0, 13'h0444, 0);
    op(0, 0, 1, 0, 0, 0, 13'h0555, 0);
    op(0, 0, 1, 0, 0, 0, 13'h0666, 0);
    op(0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    @(posedge clk) #3 rst = 0;
    #1 chk_all("async_rst", 13'h0, 3'd0, 1'b0);
    @(negedge clk) rst = 1;
    m_pc = '0;
    m_err = 0;
    m_stk.delete();
    op(0, 0, 0, 0, 0, 1, 0, 0);
    op(0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    @(posedge clk) #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
